// File: rtl/line_burst_pkg.sv
// Shared types, geometry and beat-address helper for the line burst controller.
package line_burst_pkg;

    localparam int unsigned AWIDTH  = 9;
    localparam int unsigned DWIDTH  = 8;
    localparam int unsigned BEATS   = 4;
    localparam int unsigned TIMEOUT = 15;

    localparam int unsigned BEAT_W  = $clog2(BEATS);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned LINE_W  = BEATS * DWIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    // Request captured in IDLE and held for the whole burst.
    typedef struct packed {
        logic              fill;
        logic [AWIDTH-1:0] fill_addr;
        logic [AWIDTH-1:0] wb_addr;
        logic [LINE_W-1:0] wb_line;
    } req_t;

    // Address of beat k within the line containing addr (line base | k).
    function automatic logic [AWIDTH-1:0] beat_addr(input logic [AWIDTH-1:0] addr,
                                                   input logic [BEAT_W-1:0] k);
        return (addr & ~AWIDTH'(BEATS - 1)) | AWIDTH'(k);
    endfunction

endpackage

// File: rtl/line_burst_ctrl.sv
// Line burst controller: sequences write-back and/or fill of one cache line as
// single-word memory beats, assembles the fill line and reports done/err.
module line_burst_ctrl
    import line_burst_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_fill,
    input  logic              req_wb,
    input  logic [AWIDTH-1:0] fill_addr,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_line,
    output logic [LINE_W-1:0] fill_line,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    req_t                req_q, req_d;
    logic [LINE_W-1:0]   fill_line_q, fill_line_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    // Next state, counters and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        req_d       = req_q;
        fill_line_d = fill_line_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        busy_d      = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        case (state_q)
            IDLE: begin
                if (req_wb || req_fill) begin
                    req_d.fill      = req_fill;
                    req_d.fill_addr = fill_addr;
                    req_d.wb_addr   = wb_addr;
                    req_d.wb_line   = wb_line;
                    beat_d          = '0;
                    tmo_d           = '0;
                    state_d         = req_wb ? WB : FILL;
                end
            end
            WB, FILL: begin
                if (mem_ready) begin
                    if (state_q == FILL) begin
                        fill_line_d[int'(beat_q) * int'(DWIDTH) +: DWIDTH] = mem_rdata;
                    end
                    tmo_d = '0;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_d = '0;
                        if (state_q == WB && req_q.fill) begin
                            state_d = FILL;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_d = BEAT_W'(beat_q + 1'b1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Memory never answered: abort the whole request.
                    tmo_d   = '0;
                    beat_d  = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = TMO_W'(tmo_q + 1'b1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Memory-side outputs follow the state being entered.
        busy_d = (state_d != IDLE);
        if (state_d == WB) begin
            mem_wr_d    = 1'b1;
            mem_addr_d  = beat_addr(req_d.wb_addr, beat_d);
            mem_wdata_d = req_d.wb_line[int'(beat_d) * int'(DWIDTH) +: DWIDTH];
        end else if (state_d == FILL) begin
            mem_rd_d    = 1'b1;
            mem_addr_d  = beat_addr(req_d.fill_addr, beat_d);
        end
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            tmo_q       <= '0;
            req_q       <= '0;
            fill_line_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            req_q       <= req_d;
            fill_line_q <= fill_line_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign fill_line = fill_line_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_line_burst_ctrl.sv
// Directed bench for line_burst_ctrl with a small behavioural memory.
module tb_line_burst_ctrl;

    logic        clock;
    logic        reset;
    logic        req_fill;
    logic        req_wb;
    logic [8:0]  fill_addr;
    logic [8:0]  wb_addr;
    logic [31:0] wb_line;
    logic [31:0] fill_line;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_rd;
    logic        mem_wr;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    logic [7:0]  mem [0:511];

    int n_vec = 0;
    int n_err = 0;

    line_burst_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_fill  (req_fill),
        .req_wb    (req_wb),
        .fill_addr (fill_addr),
        .wb_addr   (wb_addr),
        .wb_line   (wb_line),
        .fill_line (fill_line),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    // Read data is only meaningful on ready cycles; poison it otherwise.
    assign mem_rdata = mem_ready ? mem[mem_addr] : 8'hEE;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    // Present a request for one edge; returns at the negedge of cycle 1.
    task automatic issue(input logic f, input logic w, input logic [8:0] fa,
                         input logic [8:0] wa, input logic [31:0] wl);
        req_fill  = f;
        req_wb    = w;
        fill_addr = fa;
        wb_addr   = wa;
        wb_line   = wl;
        cyc();
        req_fill  = 1'b0;
        req_wb    = 1'b0;
    endtask

    initial begin
        int cnt_done;
        int cnt_both;
        int cnt_rd;
        int cnt_bad;
        logic [31:0] wl;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h1A4] = 8'h11; mem[9'h1A5] = 8'h22; mem[9'h1A6] = 8'h33; mem[9'h1A7] = 8'h44;
        mem[9'h120] = 8'h5A; mem[9'h121] = 8'h6B; mem[9'h122] = 8'h7C; mem[9'h123] = 8'h8D;
        mem[9'h040] = 8'hA1; mem[9'h041] = 8'hB2; mem[9'h042] = 8'hC3; mem[9'h043] = 8'hD4;

        reset = 1'b1; req_fill = 1'b0; req_wb = 1'b0;
        fill_addr = '0; wb_addr = '0; wb_line = '0; mem_ready = 1'b1;
        cyc(); cyc();

        // Reset state.
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_strb",  32'({mem_rd, mem_wr}), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_line",  fill_line, 32'd0);
        reset = 1'b0;
        cyc();

        // Fill only, ready tied high.
        mem_ready = 1'b1;
        issue(1'b1, 1'b0, 9'h1A6, 9'h000, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                check("f1_addr", 32'(mem_addr), 32'h1A4 + 32'(c - 1));
                check("f1_strb", 32'({mem_rd, mem_wr}), 32'b10);
                check("f1_done", 32'(done), 32'd0);
            end else if (c == 5) begin
                check("f1_done5", 32'(done), 32'd1);
                check("f1_err",   32'(err), 32'd0);
                check("f1_line",  fill_line, 32'h44332211);
                check("f1_strb5", 32'({mem_rd, mem_wr}), 32'd0);
            end else begin
                check("f1_idle", 32'({busy, done}), 32'd0);
            end
            cyc();
        end

        // Write-back followed by fill.
        wl = 32'hDDCCBBAA;
        cnt_done = 0; cnt_both = 0;
        issue(1'b1, 1'b1, 9'h123, 9'h0F0, wl);
        for (int c = 1; c <= 10; c++) begin
            if (mem_rd && mem_wr) cnt_both++;
            if (done) cnt_done++;
            if (c <= 4) begin
                check("wf_wr",    32'({mem_rd, mem_wr}), 32'b01);
                check("wf_waddr", 32'(mem_addr), 32'h0F0 + 32'(c - 1));
                check("wf_wdata", 32'(mem_wdata), 32'(wl[(c - 1) * 8 +: 8]));
            end else if (c <= 8) begin
                check("wf_rd",    32'({mem_rd, mem_wr}), 32'b10);
                check("wf_raddr", 32'(mem_addr), 32'h120 + 32'(c - 5));
            end else if (c == 9) begin
                check("wf_done", 32'({done, err}), 32'b10);
                check("wf_line", fill_line, 32'h8D7C6B5A);
            end
            cyc();
        end
        check("wf_ndone", 32'(cnt_done), 32'd1);
        check("wf_both",  32'(cnt_both), 32'd0);

        // Wait states: ready only on every third strobe cycle.
        mem_ready = 1'b0;
        cnt_rd = 0;
        issue(1'b1, 1'b0, 9'h042, 9'h000, 32'h0);
        for (int c = 1; c <= 13; c++) begin
            if (mem_rd) cnt_rd++;
            if (c <= 12) begin
                check("ws_addr", 32'(mem_addr), 32'h040 + 32'((c - 1) / 3));
                check("ws_rd",   32'(mem_rd), 32'd1);
                if (c == 3) check("ws_hold", fill_line, 32'h8D7C6B5A);
                if (c == 4) check("ws_w0",   fill_line, 32'h8D7C6BA1);
                mem_ready = (c % 3 == 0);
            end else begin
                mem_ready = 1'b0;
                check("ws_done", 32'({done, err}), 32'b10);
                check("ws_line", fill_line, 32'hD4C3B2A1);
            end
            cyc();
        end
        check("ws_nstrb", 32'(cnt_rd), 32'd12);

        // Timeout on write-back; fill must be skipped.
        mem_ready = 1'b0;
        cnt_rd = 0;
        issue(1'b1, 1'b1, 9'h123, 9'h0F0, 32'hDDCCBBAA);
        for (int c = 1; c <= 17; c++) begin
            if (mem_rd) cnt_rd++;
            if (c <= 15) begin
                check("to_wr",   32'(mem_wr), 32'd1);
                check("to_addr", 32'(mem_addr), 32'h0F0);
                check("to_done", 32'(done), 32'd0);
            end else if (c == 16) begin
                check("to_derr", 32'({done, err}), 32'b11);
                check("to_strb", 32'({mem_rd, mem_wr}), 32'd0);
            end else begin
                check("to_idle", 32'({busy, done, err}), 32'd0);
            end
            cyc();
        end
        check("to_nord", 32'(cnt_rd), 32'd0);
        mem_ready = 1'b1;

        // Synchronous reset mid-fill.
        cnt_done = 0;
        issue(1'b1, 1'b0, 9'h1A4, 9'h000, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            if (done) cnt_done++;
            if (c <= 2) check("rm_addr", 32'(mem_addr), 32'h1A4 + 32'(c - 1));
            if (c == 3) reset = 1'b1;
            if (c == 4) begin
                reset = 1'b0;
                check("rm_ctl",  32'({busy, done, err, mem_rd, mem_wr}), 32'd0);
                check("rm_addr0", 32'(mem_addr), 32'd0);
                check("rm_wd0",   32'(mem_wdata), 32'd0);
                check("rm_line0", fill_line, 32'd0);
            end
            if (c >= 5) check("rm_busy", 32'(busy), 32'd0);
            cyc();
        end
        check("rm_ndone", 32'(cnt_done), 32'd0);
        issue(1'b1, 1'b0, 9'h1A5, 9'h000, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) check("rm2_addr", 32'(mem_addr), 32'h1A4 + 32'(c - 1));
            else begin
                check("rm2_done", 32'({done, err}), 32'b10);
                check("rm2_line", fill_line, 32'h44332211);
            end
            cyc();
        end
        cyc();

        // Request while busy is ignored.
        cnt_done = 0; cnt_bad = 0;
        issue(1'b1, 1'b0, 9'h1A4, 9'h000, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            if (done) cnt_done++;
            if ((mem_rd || mem_wr) && mem_addr[8:2] == 7'h15) cnt_bad++;
            if (c <= 4) check("rb_addr", 32'(mem_addr), 32'h1A4 + 32'(c - 1));
            if (c == 2) begin
                req_fill  = 1'b1;
                fill_addr = 9'h055;
            end
            if (c == 3) req_fill = 1'b0;
            if (c == 9) check("rb_idle", 32'(busy), 32'd0);
            cyc();
        end
        check("rb_ndone", 32'(cnt_done), 32'd1);
        check("rb_stray", 32'(cnt_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
